fetch_stage: RTL and testbench

Instruction-fetch stage of the 16-bit custom processor. Owns the program counter and drives the 8-bit PC onto the instruction ROM address, which returns the instruction combinationally. Captures the returned instruction into the IF/ID pipeline register for the decoder. Supports stall, branch/jump redirect with flush, and halting at end of program.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/ifid_reg.sv | 41 ++++
 rtl/fetch_stage.sv | 93 +++++++++
 tb/tb_fetch_stage.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants, types and helpers for the 16-bit processor pipeline.
// Fetch-stage sizing plus the opcode field position used by downstream stages.
package cpu_pkg;

  localparam int unsigned PC_W     = 8;
  localparam int unsigned INSTR_W  = 16;
  localparam int unsigned PROG_LEN = 13;
  localparam logic [PC_W-1:0] RESET_PC = '0;

  // Opcode field within an instruction word, consumed by the decoder.
  localparam int unsigned OPC_LSB = 0;
  localparam int unsigned OPC_MSB = 3;

  typedef enum logic [0:0] {
    StRun,
    StHalt
  } fetch_state_e;

  function automatic logic in_prog(input logic [PC_W-1:0] pc);
    return 32'(pc) < PROG_LEN;
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register with load, flush and hold controls.
// A flush clears valid and zeroes the instruction, since opcode 0 is ADD rather than a NOP.
module ifid_reg
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               flush_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pc_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o,
  output logic               valid_o
);

  logic [INSTR_W-1:0] instr_q;
  logic [PC_W-1:0]    pc_q;
  logic               valid_q;

  // Flush wins over load; pc is kept on flush, as it carries no meaning while invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      instr_q <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
      valid_q <= 1'b1;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the ROM address and fills the IF/ID register.
// Priority each cycle is redirect, then stall, then normal advance; fetch halts past the program.
module fetch_stage
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  input  logic [INSTR_W-1:0] rom_instr_i,
  output logic [PC_W-1:0]    pc_o,
  output logic [INSTR_W-1:0] ifid_instr_o,
  output logic [PC_W-1:0]    ifid_pc_o,
  output logic               ifid_valid_o,
  output logic               halted_o,
  output logic [15:0]        fetch_cnt_o
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            pc_in_prog;
  logic            load, flush;

  assign pc_in_prog = in_prog(pc_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (redirect_i) begin
      state_d = in_prog(redirect_pc_i) ? StRun : StHalt;
    end else if (state_q == StRun && !stall_i && !pc_in_prog) begin
      state_d = StHalt;
    end
  end

  always_comb begin
    load     = 1'b0;
    flush    = 1'b0;
    halted_o = 1'b0;
    unique case (state_q)
      StRun: begin
        load  = !redirect_i && !stall_i && pc_in_prog;
        flush = redirect_i || (!stall_i && !pc_in_prog);
      end
      StHalt: begin
        halted_o = 1'b1;
        flush    = 1'b1;
      end
      default: ;
    endcase
  end

  // PC wraps modulo 2^PC_W, but the range check halts fetch before that can happen.
  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    if (redirect_i) begin
      pc_d = redirect_pc_i;
    end else if (load) begin
      pc_d  = pc_q + 1'b1;
      cnt_d = cnt_q + 16'd1;
    end
  end

  ifid_reg u_ifid_reg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .flush_i (flush),
    .instr_i (rom_instr_i),
    .pc_i    (pc_q),
    .instr_o (ifid_instr_o),
    .pc_o    (ifid_pc_o),
    .valid_o (ifid_valid_o)
  );

  assign pc_o        = pc_q;
  assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus queues expected IF/ID deliveries, a monitor checks them.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        redirect_i;
  logic [7:0]  redirect_pc_i;
  logic [15:0] rom_instr_i;
  logic [7:0]  pc_o;
  logic [15:0] ifid_instr_o;
  logic [7:0]  ifid_pc_o;
  logic        ifid_valid_o;
  logic        halted_o;
  logic [15:0] fetch_cnt_o;

  typedef struct packed {
    logic [15:0] instr;
    logic [7:0]  pc;
    logic [15:0] cnt;
  } deliv_t;

  deliv_t      exp_q[$];
  logic [15:0] rom [256];
  int          total;
  int          passed;
  logic        last_valid;
  logic [7:0]  last_pc;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .rom_instr_i   (rom_instr_i),
    .pc_o          (pc_o),
    .ifid_instr_o  (ifid_instr_o),
    .ifid_pc_o     (ifid_pc_o),
    .ifid_valid_o  (ifid_valid_o),
    .halted_o      (halted_o),
    .fetch_cnt_o   (fetch_cnt_o)
  );

  assign rom_instr_i = rom[pc_o];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h, expected %h", name, got, want);
  endtask

  // One clock: drive inputs, optionally queue the delivery expected at this edge.
  task automatic tick(input logic st, input logic rd, input logic [7:0] rpc, input bit dlv,
                      input logic [7:0] dpc, input logic [15:0] dcnt);
    stall_i       = st;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    if (dlv) exp_q.push_back('{instr: rom[dpc], pc: dpc, cnt: dcnt});
    @(posedge clk);
    @(negedge clk);
    stall_i    = 1'b0;
    redirect_i = 1'b0;
  endtask

  // A new delivery is a valid word that is not the same word held through a stall.
  always @(negedge clk) begin
    if (ifid_valid_o && !(last_valid && ifid_pc_o == last_pc)) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_delivery: got pc %h, expected no delivery", ifid_pc_o);
      end else begin
        deliv_t e;
        e = exp_q.pop_front();
        chk("deliv_instr", 32'(ifid_instr_o), 32'(e.instr));
        chk("deliv_pc", 32'(ifid_pc_o), 32'(e.pc));
        chk("deliv_cnt", 32'(fetch_cnt_o), 32'(e.cnt));
      end
    end
    if (!ifid_valid_o) chk("instr_zero_when_invalid", 32'(ifid_instr_o), 32'h0);
    last_valid = ifid_valid_o;
    last_pc    = ifid_pc_o;
  end

  initial begin
    total = 0;
    passed = 0;
    last_valid = 1'b0;
    last_pc = 8'h00;
    for (int i = 0; i < 256; i++) rom[i] = 16'hDEAD;
    rom[0] = 16'h0880;
    rom[1] = 16'h4811;
    for (int i = 2; i < 13; i++) rom[i] = 16'h1000 + 16'(i * 16'h0111);
    stall_i = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = 8'h00;
    rst = 1'b1;
    #2;
    chk("rst_pc", 32'(pc_o), 32'h0);
    chk("rst_valid", 32'(ifid_valid_o), 32'h0);
    chk("rst_halted", 32'(halted_o), 32'h0);
    chk("rst_cnt", 32'(fetch_cnt_o), 32'h0);
    chk("rst_ifid_pc", 32'(ifid_pc_o), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Normal fetch of the first words.
    tick(0, 0, 8'h00, 1, 8'd0, 16'd1);
    chk("pc_after_1", 32'(pc_o), 32'd1);
    tick(0, 0, 8'h00, 1, 8'd1, 16'd2);
    chk("pc_after_2", 32'(pc_o), 32'd2);
    tick(0, 0, 8'h00, 1, 8'd2, 16'd3);
    tick(0, 0, 8'h00, 1, 8'd3, 16'd4);

    // Three stall cycles at pc=4 hold everything.
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 8'h00, 0, 8'd0, 16'd0);
      chk("stall_pc", 32'(pc_o), 32'd4);
      chk("stall_ifid_pc", 32'(ifid_pc_o), 32'd3);
      chk("stall_cnt", 32'(fetch_cnt_o), 32'd4);
      chk("stall_valid", 32'(ifid_valid_o), 32'd1);
    end
    tick(0, 0, 8'h00, 1, 8'd4, 16'd5);
    chk("pc_after_stall", 32'(pc_o), 32'd5);

    // Redirect beats a simultaneous stall; one bubble follows.
    tick(1, 1, 8'd9, 0, 8'd0, 16'd0);
    chk("redir_pc", 32'(pc_o), 32'd9);
    chk("redir_valid", 32'(ifid_valid_o), 32'd0);
    tick(0, 0, 8'h00, 1, 8'd9, 16'd6);
    tick(0, 0, 8'h00, 1, 8'd10, 16'd7);
    tick(0, 0, 8'h00, 1, 8'd11, 16'd8);
    tick(0, 0, 8'h00, 1, 8'd12, 16'd9);
    chk("pc_at_end", 32'(pc_o), 32'd13);

    // pc=13 is outside the program: halt.
    tick(0, 0, 8'h00, 0, 8'd0, 16'd0);
    chk("halt_flag", 32'(halted_o), 32'd1);
    chk("halt_pc", 32'(pc_o), 32'd13);
    chk("halt_valid", 32'(ifid_valid_o), 32'd0);
    chk("halt_cnt", 32'(fetch_cnt_o), 32'd9);
    tick(1, 0, 8'h00, 0, 8'd0, 16'd0);
    chk("halt_stall_pc", 32'(pc_o), 32'd13);
    chk("halt_stall_flag", 32'(halted_o), 32'd1);

    // Redirect out of HALT resumes fetch; redirect beyond the program re-enters HALT.
    tick(0, 1, 8'd2, 0, 8'd0, 16'd0);
    chk("resume_halted", 32'(halted_o), 32'd0);
    chk("resume_pc", 32'(pc_o), 32'd2);
    tick(0, 0, 8'h00, 1, 8'd2, 16'd10);
    tick(0, 1, 8'd200, 0, 8'd0, 16'd0);
    chk("far_halted", 32'(halted_o), 32'd1);
    chk("far_pc", 32'(pc_o), 32'd200);
    tick(0, 0, 8'h00, 0, 8'd0, 16'd0);
    chk("far_hold_pc", 32'(pc_o), 32'd200);
    chk("far_hold_halted", 32'(halted_o), 32'd1);
    chk("far_hold_cnt", 32'(fetch_cnt_o), 32'd10);

    // Bring pc to 7 with a valid word, then reset asynchronously between edges.
    tick(0, 1, 8'd5, 0, 8'd0, 16'd0);
    tick(0, 0, 8'h00, 1, 8'd5, 16'd11);
    tick(0, 0, 8'h00, 1, 8'd6, 16'd12);
    chk("pre_rst_pc", 32'(pc_o), 32'd7);
    chk("pre_rst_valid", 32'(ifid_valid_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pc", 32'(pc_o), 32'd0);
    chk("async_rst_valid", 32'(ifid_valid_o), 32'd0);
    chk("async_rst_instr", 32'(ifid_instr_o), 32'd0);
    chk("async_rst_ifid_pc", 32'(ifid_pc_o), 32'd0);
    chk("async_rst_cnt", 32'(fetch_cnt_o), 32'd0);
    chk("async_rst_halted", 32'(halted_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Straight run through the whole program.
    for (int i = 0; i < 13; i++) tick(0, 0, 8'h00, 1, 8'(i), 16'(i + 1));
    tick(0, 0, 8'h00, 0, 8'd0, 16'd0);
    chk("run_end_pc", 32'(pc_o), 32'd13);
    chk("run_end_halted", 32'(halted_o), 32'd1);
    chk("run_end_valid", 32'(ifid_valid_o), 32'd0);
    chk("run_end_cnt", 32'(fetch_cnt_o), 32'd13);
    chk("run_end_ifid_pc", 32'(ifid_pc_o), 32'd12);

    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
